mem_port_arbiter: RTL

- Shares the single data-SRAM port between the instruction-fetch requester (IF) and the load/store requester (MEM stage).
- Sequences each access over a split address/data handshake and generates byte strobes and write-data replication.
- Raises per-requester stall requests into the pipeline stall controller until each access completes.
- Sits between IF/MEM and the external SRAM bus.

---
 rtl/mem_port_arbiter_pkg.sv | 28 ++
 rtl/mem_lane_gen.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the data-SRAM port arbiter.
// State, owner and access-size codes plus the latched access bundle.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef struct packed {
        owner_e      owner;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        wr;
        logic [31:0] wdata;
    } access_t;

endpackage

// File: rtl/mem_lane_gen.sv
// Byte-lane generator: strobes, write-data replication and alignment check.
// Purely combinational; reserved size code 2'b11 is flagged misaligned.
module mem_lane_gen
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        wr,
    input  logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_rep,
    output logic        misaligned
);

    logic [3:0] strb;

    // Decode size/offset into lane strobes and replicated store data.
    always_comb begin
        strb       = 4'b0000;
        wdata_rep  = wdata;
        misaligned = 1'b0;
        unique case (size)
            SIZE_B: begin
                strb      = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            SIZE_H: begin
                strb       = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep  = {2{wdata[15:0]}};
                misaligned = addr_lo[0];
            end
            SIZE_W: begin
                strb       = 4'b1111;
                misaligned = |addr_lo;
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
        wstrb = wr ? strb : 4'b0000;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single data-SRAM port between fetch and load/store.
// Optional watchdog enabled by defining MEM_PORT_TIMEOUT_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_DATA_RUN   = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_ok,
    output logic        data_err,
    output logic [31:0] data_rdata,
    output logic        stallreq_inst,
    output logic        stallreq_data,
    output logic        sram_req,
    output logic        sram_wr,
    output logic [3:0]  sram_wstrb,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic        sram_addr_ok,
    input  logic        sram_data_ok,
    input  logic [31:0] sram_rdata
);

    localparam logic [7:0] RUN_MAX = 8'(MAX_DATA_RUN);

    if (TIMEOUT_CYCLES < 1 || MAX_DATA_RUN < 0) begin : g_param_check
        $error("mem_port_arbiter: bad parameter value");
    end

    state_e      state_q;
    state_e      state_d;
    access_t     acc_q;
    access_t     acc_d;
    logic [7:0]  run_q;
    logic [7:0]  run_d;
    logic        timeout;
    logic        done;
    logic        in_idle;

    logic [1:0]  lg_size;
    logic [1:0]  lg_addr;
    logic        lg_wr;
    logic [31:0] lg_wdata;
    logic [3:0]  lg_wstrb;
    logic [31:0] lg_wdata_rep;
    logic        lg_misaligned;

    assign in_idle = (state_q == ST_IDLE);

    // In IDLE the lane generator checks the live request for alignment;
    // once granted it shapes the bus fields from the latched access.
    assign lg_size  = in_idle ? data_size      : acc_q.size;
    assign lg_addr  = in_idle ? data_addr[1:0] : acc_q.addr[1:0];
    assign lg_wr    = in_idle ? data_wr        : acc_q.wr;
    assign lg_wdata = in_idle ? data_wdata     : acc_q.wdata;

    mem_lane_gen u_lane (
        .size       (lg_size),
        .addr_lo    (lg_addr),
        .wr         (lg_wr),
        .wdata      (lg_wdata),
        .wstrb      (lg_wstrb),
        .wdata_rep  (lg_wdata_rep),
        .misaligned (lg_misaligned)
    );

`ifdef MEM_PORT_TIMEOUT_EN
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wdog_q;

    // Count cycles spent on the bus; cleared whenever the port is idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_q <= '0;
        end else if (in_idle) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_q + 16'd1;
        end
    end

    // A real data phase completing on the last cycle beats the watchdog.
    assign timeout = !in_idle && (wdog_q == WDOG_LAST) &&
                     !(state_q == ST_DATA && sram_data_ok);
`else
    assign timeout = 1'b0;
`endif

    // State, latched access and data-run counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            run_q   <= run_d;
        end
    end

    // Arbitration, bus sequencing and completion routing.
    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        run_d         = run_q;
        done          = 1'b0;
        inst_ok       = 1'b0;
        inst_rdata    = '0;
        data_ok       = 1'b0;
        data_err      = 1'b0;
        data_rdata    = '0;
        sram_req      = 1'b0;
        sram_wr       = 1'b0;
        sram_wstrb    = 4'b0000;
        sram_addr     = '0;
        sram_wdata    = '0;
        stallreq_inst = 1'b0;
        stallreq_data = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!data_req) begin
                    run_d = '0;
                end
                if (data_req && lg_misaligned) begin
                    data_ok  = 1'b1;
                    data_err = 1'b1;
                end else if (data_req &&
                             (!inst_req || run_q != RUN_MAX)) begin
                    state_d = ST_ADDR;
                    acc_d   = '{owner: OWN_DATA,
                                addr:  data_addr,
                                size:  data_size,
                                wr:    data_wr,
                                wdata: data_wdata};
                    if (inst_req && run_q != RUN_MAX) begin
                        run_d = run_q + 8'd1;
                    end
                end else if (inst_req) begin
                    state_d = ST_ADDR;
                    acc_d   = '{owner: OWN_INST,
                                addr:  inst_addr,
                                size:  SIZE_W,
                                wr:    1'b0,
                                wdata: '0};
                    run_d   = '0;
                end
            end
            ST_ADDR: begin
                if (timeout) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    sram_req   = 1'b1;
                    sram_wr    = acc_q.wr;
                    sram_wstrb = lg_wstrb;
                    sram_addr  = {acc_q.addr[31:2], 2'b00};
                    sram_wdata = lg_wdata_rep;
                    if (sram_addr_ok) begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (sram_data_ok || timeout) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (done) begin
            if (acc_q.owner == OWN_DATA) begin
                data_ok    = 1'b1;
                data_err   = timeout;
                data_rdata = timeout ? '0 : sram_rdata;
            end else begin
                inst_ok    = 1'b1;
                inst_rdata = timeout ? '0 : sram_rdata;
            end
        end

        stallreq_inst = inst_req & ~inst_ok;
        stallreq_data = data_req & ~data_ok;

        // Reset forces every output low, not just the registered state.
        if (!rst) begin
            inst_ok       = 1'b0;
            inst_rdata    = '0;
            data_ok       = 1'b0;
            data_err      = 1'b0;
            data_rdata    = '0;
            sram_req      = 1'b0;
            sram_wr       = 1'b0;
            sram_wstrb    = 4'b0000;
            sram_addr     = '0;
            sram_wdata    = '0;
            stallreq_inst = 1'b0;
            stallreq_data = 1'b0;
        end
    end

endmodule
